// File: rtl/rf_cached_multiread_if.sv
// Operand-read / register-write bus for rf_cached_multiread.
// Addresses and read data are flat vectors; port i occupies slice i.
interface rf_cached_multiread_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 8,
    parameter int NPORTS = 4
);
    logic [NPORTS-1:0]        req;
    logic [NPORTS*ADDR_W-1:0] addr;
    logic [NPORTS-1:0]        valid;
    logic [NPORTS*DATA_W-1:0] rdata;
    logic                     we;
    logic [ADDR_W-1:0]        wa;
    logic [DATA_W-1:0]        wd;
    logic                     busy;

    modport master (output req, addr, we, wa, wd, input valid, rdata, busy);
    modport slave  (input req, addr, we, wa, wd, output valid, rdata, busy);
endinterface

// File: rtl/rf_cached_multiread.sv
// Multi-port register file: NPORTS one-entry tagged caches in front of a
// single 1R1W SRAM, misses filled one per cycle by a round-robin arbiter.
module rf_cached_entry #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 8,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              fill_en,
    input  logic [ADDR_W-1:0] fill_tag,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    output logic              hit,
    output logic              valid,
    output logic [DATA_W-1:0] rdata
);
    logic              tv;
    logic [ADDR_W-1:0] tag;
    logic [DATA_W-1:0] data;
    logic              wr_match;

    assign hit      = tv && (tag == addr);
    assign valid    = !req || hit;
    assign rdata    = data;
    assign wr_match = we && tv && (tag == wa);

    // A fill already carries any same-cycle write, so it takes priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tv   <= 1'b0;
            tag  <= '0;
            data <= '0;
        end else if (fill_en) begin
            tv   <= 1'b1;
            tag  <= fill_tag;
            data <= fill_data;
        end else if (wr_match) begin
            if (BYPASS) data <= wd;
            else        tv   <= 1'b0;
        end
    end
endmodule

module rf_cached_multiread #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 8,
    parameter int NPORTS = 4,
    parameter bit BYPASS = 1'b1
) (
    input logic                  clk,
    input logic                  reset,
    rf_cached_multiread_if.slave bus
);
    localparam int RR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic [NPORTS-1:0][ADDR_W-1:0] addr_a;
    logic [NPORTS-1:0][DATA_W-1:0] rdata_a;
    logic [NPORTS-1:0]             hit, miss, fill_en, valid_a;

    logic [RR_W-1:0]   rr, rr_nxt, fport, gnt_idx;
    logic              gnt_any, inflight, fwd_hit;
    logic [ADDR_W-1:0] faddr;
    logic [DATA_W-1:0] fwd_data, sram_q, fill_data;
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    int                p;

    assign addr_a    = bus.addr;
    assign bus.rdata = rdata_a;
    assign bus.valid = valid_a;
    assign bus.busy  = inflight;

    genvar i;
    generate
        for (i = 0; i < NPORTS; i++) begin : g_port
            // The port being filled sits out arbitration so it is not granted twice.
            assign fill_en[i] = inflight && (fport == RR_W'(i));
            assign miss[i]    = bus.req[i] && !hit[i] && !fill_en[i];

            rf_cached_entry #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_entry (
                .clk       (clk),
                .reset     (reset),
                .req       (bus.req[i]),
                .addr      (addr_a[i]),
                .fill_en   (fill_en[i]),
                .fill_tag  (faddr),
                .fill_data (fill_data),
                .we        (bus.we),
                .wa        (bus.wa),
                .wd        (bus.wd),
                .hit       (hit[i]),
                .valid     (valid_a[i]),
                .rdata     (rdata_a[i])
            );
        end
    endgenerate

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        p       = 0;
        for (int k = 0; k < NPORTS; k++) begin
            p = (int'(rr) + k) % NPORTS;
            if (!gnt_any && miss[p]) begin
                gnt_any = 1'b1;
                gnt_idx = RR_W'(p);
            end
        end
    end

    assign rr_nxt = (int'(gnt_idx) == NPORTS - 1) ? '0 : gnt_idx + 1'b1;

    // Read-after-write ordering: a fill-cycle write beats a grant-cycle
    // write, which beats the (stale) SRAM read.
    assign fill_data = (bus.we && bus.wa == faddr) ? bus.wd :
                       fwd_hit                     ? fwd_data : sram_q;

    always_ff @(posedge clk) begin
        if (bus.we) mem[bus.wa] <= bus.wd;
        sram_q <= mem[addr_a[gnt_idx]];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr       <= '0;
            inflight <= 1'b0;
            fport    <= '0;
            faddr    <= '0;
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
        end else begin
            inflight <= gnt_any;
            fwd_hit  <= gnt_any && bus.we && (bus.wa == addr_a[gnt_idx]);
            fwd_data <= bus.wd;
            if (gnt_any) begin
                fport <= gnt_idx;
                faddr <= addr_a[gnt_idx];
                rr    <= rr_nxt;
            end
        end
    end
endmodule

// File: tb/tb_rf_cached_multiread.sv
// Self-checking bench: a BYPASS=1 and a BYPASS=0 instance share stimulus and
// are checked against a plain memory model and per-scenario timing rules.
module tb_rf_cached_multiread;
    localparam int DW = 64;
    localparam int AW = 8;
    localparam int NP = 4;

    logic clk, reset;
    int   n_chk, n_fail;
    logic [DW-1:0] mem_m [0:255];

    rf_cached_multiread_if #(.DATA_W(DW), .ADDR_W(AW), .NPORTS(NP)) bus1 ();
    rf_cached_multiread_if #(.DATA_W(DW), .ADDR_W(AW), .NPORTS(NP)) bus0 ();

    rf_cached_multiread #(.DATA_W(DW), .ADDR_W(AW), .NPORTS(NP), .BYPASS(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));
    rf_cached_multiread #(.DATA_W(DW), .ADDR_W(AW), .NPORTS(NP), .BYPASS(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));

    assign bus0.req  = bus1.req;
    assign bus0.addr = bus1.addr;
    assign bus0.we   = bus1.we;
    assign bus0.wa   = bus1.wa;
    assign bus0.wd   = bus1.wd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [DW-1:0] rd1(int i);
        return bus1.rdata[i*DW +: DW];
    endfunction
    function automatic logic [DW-1:0] rd0(int i);
        return bus0.rdata[i*DW +: DW];
    endfunction
    function automatic logic [AW-1:0] pa(int i);
        return bus1.addr[i*AW +: AW];
    endfunction

    task automatic set_addr(int i, logic [AW-1:0] a);
        bus1.addr[i*AW +: AW] = a;
    endtask

    // Advance one clock; the model memory takes the write at the same edge.
    task automatic cyc();
        @(posedge clk);
        if (bus1.we === 1'b1) mem_m[bus1.wa] = bus1.wd;
        #1;
    endtask

    task automatic idle();
        bus1.req = '0; bus1.addr = '0; bus1.we = 1'b0; bus1.wa = '0; bus1.wd = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic wr(logic [AW-1:0] a, logic [DW-1:0] d);
        bus1.we = 1'b1; bus1.wa = a; bus1.wd = d;
        cyc();
        bus1.we = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        bus1.req = 4'b0101;
        #2;
        n_chk++; if (bus1.valid !== 4'b1010) begin n_fail++; $display("FAIL reset_valid: got %b expected %b", bus1.valid, 4'b1010); end
        n_chk++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus1.busy); end
        n_chk++; if (bus1.rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", bus1.rdata); end
        bus1.req = '0;
        #1;
        n_chk++; if (bus1.valid !== 4'b1111) begin n_fail++; $display("FAIL reset_valid_idle: got %b expected 1111", bus1.valid); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        wr(8'd5, 64'h1234);
        bus1.req[0] = 1'b1; set_addr(0, 8'd5);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_chk++; if (bus1.valid[0] !== (c == 2)) begin n_fail++; $display("FAIL single_valid c=%0d: got %b expected %b", c, bus1.valid[0], c == 2); end
            n_chk++; if (bus1.busy !== (c == 1)) begin n_fail++; $display("FAIL single_busy c=%0d: got %b expected %b", c, bus1.busy, c == 1); end
            if (c == 2) begin
                n_chk++; if (rd1(0) !== 64'h1234) begin n_fail++; $display("FAIL single_data: got %h expected %h", rd1(0), 64'h1234); end
            end
            cyc();
        end
        idle();
    endtask

    task automatic test_multi_miss();
        logic [DW-1:0] exp_d;
        do_reset();
        for (int a = 1; a <= 4; a++) wr(AW'(a), DW'(a * 'h11));
        bus1.req = 4'hF;
        for (int i = 0; i < NP; i++) set_addr(i, AW'(i + 1));
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int i = 0; i < NP; i++) begin
                n_chk++; if (bus1.valid[i] !== (c >= 2 + i)) begin n_fail++; $display("FAIL multi_valid p%0d c=%0d: got %b expected %b", i, c, bus1.valid[i], c >= 2 + i); end
                if (c >= 2 + i) begin
                    exp_d = DW'((i + 1) * 'h11);
                    n_chk++; if (rd1(i) !== exp_d) begin n_fail++; $display("FAIL multi_data p%0d: got %h expected %h", i, rd1(i), exp_d); end
                end
            end
            n_chk++; if (bus1.busy !== (c >= 1 && c <= 4)) begin n_fail++; $display("FAIL multi_busy c=%0d: got %b", c, bus1.busy); end
            cyc();
        end
        n_chk++; if (dut1.rr !== '0) begin n_fail++; $display("FAIL multi_rr: got %0d expected 0", dut1.rr); end
        idle();
    endtask

    task automatic test_write_hit();
        do_reset();
        wr(8'd7, 64'h77);
        bus1.req[1] = 1'b1; set_addr(1, 8'd7);
        cyc(); cyc();
        @(negedge clk);
        n_chk++; if (bus1.valid[1] !== 1'b1 || rd1(1) !== 64'h77) begin n_fail++; $display("FAIL wh_pre1: got v=%b d=%h expected v=1 d=77", bus1.valid[1], rd1(1)); end
        n_chk++; if (bus0.valid[1] !== 1'b1 || rd0(1) !== 64'h77) begin n_fail++; $display("FAIL wh_pre0: got v=%b d=%h expected v=1 d=77", bus0.valid[1], rd0(1)); end
        cyc();
        bus1.we = 1'b1; bus1.wa = 8'd7; bus1.wd = 64'hDEAD;
        @(negedge clk);
        n_chk++; if (bus1.valid[1] !== 1'b1) begin n_fail++; $display("FAIL wh_wcycle: got %b expected 1", bus1.valid[1]); end
        cyc();
        bus1.we = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_chk++; if (bus1.valid[1] !== 1'b1 || rd1(1) !== 64'hDEAD) begin n_fail++; $display("FAIL wh_byp c=%0d: got v=%b d=%h expected v=1 d=dead", c, bus1.valid[1], rd1(1)); end
            n_chk++; if (bus0.valid[1] !== (c == 2)) begin n_fail++; $display("FAIL wh_inv_valid c=%0d: got %b expected %b", c, bus0.valid[1], c == 2); end
            if (c == 2) begin
                n_chk++; if (rd0(1) !== 64'hDEAD) begin n_fail++; $display("FAIL wh_inv_data: got %h expected dead", rd0(1)); end
            end
            cyc();
        end
        idle();
    endtask

    task automatic test_fill_forward();
        for (int s = 0; s < 2; s++) begin
            do_reset();
            wr(8'd9, 64'h1);
            bus1.req[2] = 1'b1; set_addr(2, 8'd9);
            if (s == 0) begin bus1.we = 1'b1; bus1.wa = 8'd9; bus1.wd = 64'hBEEF; end
            @(negedge clk);
            n_chk++; if (bus1.valid[2] !== 1'b0) begin n_fail++; $display("FAIL fwd_grant s=%0d: got %b expected 0", s, bus1.valid[2]); end
            cyc();
            bus1.we = 1'b0;
            if (s == 1) begin bus1.we = 1'b1; bus1.wa = 8'd9; bus1.wd = 64'hBEEF; end
            @(negedge clk);
            n_chk++; if (bus1.valid[2] !== 1'b0) begin n_fail++; $display("FAIL fwd_fill s=%0d: got %b expected 0", s, bus1.valid[2]); end
            cyc();
            bus1.we = 1'b0;
            @(negedge clk);
            n_chk++; if (bus1.valid[2] !== 1'b1 || rd1(2) !== 64'hBEEF) begin n_fail++; $display("FAIL fwd_data1 s=%0d: got v=%b d=%h expected v=1 d=beef", s, bus1.valid[2], rd1(2)); end
            n_chk++; if (bus0.valid[2] !== 1'b1 || rd0(2) !== 64'hBEEF) begin n_fail++; $display("FAIL fwd_data0 s=%0d: got v=%b d=%h expected v=1 d=beef", s, bus0.valid[2], rd0(2)); end
            cyc();
            idle();
        end
    endtask

    task automatic test_fairness();
        int seen;
        logic [DW-1:0] v;
        v = {$urandom, $urandom};
        do_reset();
        wr(8'h20, v);
        bus1.req = 4'b1001; set_addr(3, 8'h20);
        seen = -1;
        for (int c = 0; c < 20; c++) begin
            set_addr(0, AW'(8'h40 + c));
            @(negedge clk);
            n_chk++; if (bus1.valid[0] !== 1'b0) begin n_fail++; $display("FAIL fair_p0 c=%0d: got %b expected 0", c, bus1.valid[0]); end
            if (seen < 0 && bus1.valid[3] === 1'b1) begin
                seen = c;
                n_chk++; if (rd1(3) !== v) begin n_fail++; $display("FAIL fair_data: got %h expected %h", rd1(3), v); end
            end
            cyc();
        end
        n_chk++; if (seen < 0 || seen > NP + 1) begin n_fail++; $display("FAIL fair_latency: got %0d expected 0..%0d", seen, NP + 1); end
        idle();
    endtask

    task automatic test_reset_midfill();
        logic [DW-1:0] v;
        v = {$urandom, $urandom};
        do_reset();
        wr(8'h30, v);
        bus1.req[1] = 1'b1; set_addr(1, 8'h30);
        @(negedge clk);
        n_chk++; if (bus1.valid[1] !== 1'b0) begin n_fail++; $display("FAIL rst_grant: got %b expected 0", bus1.valid[1]); end
        cyc();
        #2;
        n_chk++; if (bus1.busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy_pre: got %b expected 1", bus1.busy); end
        reset = 1'b1;
        #1;
        n_chk++; if (bus1.busy !== 1'b0 || bus1.valid[1] !== 1'b0) begin n_fail++; $display("FAIL rst_async: got busy=%b v=%b expected 0 0", bus1.busy, bus1.valid[1]); end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_chk++; if (bus1.valid[1] !== (c == 2)) begin n_fail++; $display("FAIL rst_refill_v c=%0d: got %b expected %b", c, bus1.valid[1], c == 2); end
            n_chk++; if (bus1.busy !== (c == 1)) begin n_fail++; $display("FAIL rst_refill_busy c=%0d: got %b expected %b", c, bus1.busy, c == 1); end
            if (c == 2) begin
                n_chk++; if (rd1(1) !== v) begin n_fail++; $display("FAIL rst_refill_data: got %h expected %h", rd1(1), v); end
            end
            cyc();
        end
        idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int a = 0; a < 16; a++) wr(AW'(a), {$urandom, $urandom});
        for (int ph = 0; ph < 30; ph++) begin
            bus1.req = NP'($urandom);
            for (int i = 0; i < NP; i++) set_addr(i, AW'($urandom_range(0, 15)));
            for (int c = 0; c < 8; c++) begin
                bus1.we = 1'($urandom);
                bus1.wa = AW'($urandom_range(0, 15));
                bus1.wd = {$urandom, $urandom};
                @(negedge clk);
                for (int i = 0; i < NP; i++) begin
                    if (!bus1.req[i]) begin
                        n_chk++; if (bus1.valid[i] !== 1'b1) begin n_fail++; $display("FAIL rnd_idle ph%0d p%0d: got %b expected 1", ph, i, bus1.valid[i]); end
                    end else begin
                        if (bus1.valid[i] === 1'b1) begin
                            n_chk++; if (rd1(i) !== mem_m[pa(i)]) begin n_fail++; $display("FAIL rnd_data1 ph%0d p%0d: got %h expected %h", ph, i, rd1(i), mem_m[pa(i)]); end
                        end
                        if (bus0.valid[i] === 1'b1) begin
                            n_chk++; if (rd0(i) !== mem_m[pa(i)]) begin n_fail++; $display("FAIL rnd_data0 ph%0d p%0d: got %h expected %h", ph, i, rd0(i), mem_m[pa(i)]); end
                        end
                        if (c == 7) begin
                            n_chk++; if (bus1.valid[i] !== 1'b1) begin n_fail++; $display("FAIL rnd_live ph%0d p%0d: got %b expected 1", ph, i, bus1.valid[i]); end
                        end
                    end
                end
                cyc();
            end
        end
        idle();
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        reset = 1'b1;
        idle();
        test_reset();
        test_single_read();
        test_multi_miss();
        test_write_hit();
        test_fill_forward();
        test_fairness();
        test_reset_midfill();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_cached_multiread.md
# rf_cached_multiread

Parametrised multi-port register file for the MMIX core. It serves NPORTS independent read ports (operand fetch: y, z, b, rA, and extra ports as needed) from a single 1R1W synchronous SRAM. Each port keeps a one-entry tagged cache. Misses are filled by a round-robin arbiter, and writes update cached copies in place rather than forcing a refetch. It sits between the issue stage's operand-spec decode and the register-write path, one instance each for the global and the local register files.

## Interface
- DATA_W, 64, register width in bits
- ADDR_W, 8, register address width; depth = 2**ADDR_W
- NPORTS, 4, number of read ports (1..8)
- BYPASS, 1, 1 = write-update matching cache entries; 0 = invalidate them
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  NPORTS  port i requests a read of addr[i]
- addr  in  NPORTS*ADDR_W  read address, port i at bits [i*ADDR_W +: ADDR_W]
- valid  out  NPORTS  rdata[i] holds the current value of addr[i]
- rdata  out  NPORTS*DATA_W  cached read data for port i
- we  in  1  write enable
- wa  in  ADDR_W  write address
- wd  in  DATA_W  write data
- busy  out  1  a fill is in flight

## Operation
- Per-port state: tag[i] (ADDR_W), tv[i] (tag valid), data[i] (DATA_W). rdata[i] = data[i].
- Hit and valid:
  - hit[i] = tv[i] & (tag[i] == addr[i]).
  - valid[i] = ~req[i] | hit[i]. This is combinational on req and addr.
- Miss: miss[i] = req[i] & ~hit[i] & ~(inflight & fport == i).
- Arbiter:
  - Round-robin pointer rr (clog2(NPORTS) bits).
  - Grants the first port with miss set, searching from rr upward with wrap.
  - On a grant g: SRAM read address = addr[g] in the same cycle. Register inflight=1, fport=g, faddr=addr[g]. rr <= (g+1) mod NPORTS.
  - No grant: inflight <= 0.
  - One grant per cycle. Grants may be issued back-to-back.
- Fill, in the cycle after the grant:
  - tag[fport] <= faddr, tv[fport] <= 1.
  - Data source, in priority order:
    - wd if we & wa == faddr in this (fill) cycle;
    - else fwd_data if a write to faddr occurred in the grant cycle (captured in fwd_hit/fwd_data);
    - else SRAM read data.
  - If addr[fport] changed while in flight, the fill still lands with tag=faddr. valid stays low and the port misses again.
- Write path:
  - SRAM is written at wa with wd. Reads are never stalled by writes.
  - For each port j with tv[j] & tag[j]==wa, excluding a port filled this cycle:
    - BYPASS=1: data[j] <= wd.
    - BYPASS=0: tv[j] <= 0.
- Tag width follows ADDR_W and data width follows DATA_W. No truncation; addresses wrap naturally at 2**ADDR_W.

## Timing
- Reset values:
  - tv=0, tag=0, data=0, rr=0, inflight=0, fwd_hit=0.
  - Outputs: busy=0, rdata=0, valid = ~req.
  - SRAM contents are not reset.
- Miss-to-valid latency: 2 cycles minimum.
  - Miss visible in cycle t and granted in t.
  - SRAM data registered at the end of t.
  - Entry filled at the end of t+1; valid high in t+2.
- With k simultaneous misses, worst-case valid latency is k+1 cycles.
- Write-to-hit visibility, BYPASS=1: a write in cycle t is reflected in rdata from t+1 and valid stays high.
- Write-to-hit visibility, BYPASS=0: valid drops in t+1 and refill completes by t+3 if the port is granted in t+1.
- A write to the in-flight address at the grant cycle or the fill cycle is never lost (read-after-write ordering holds).
- Reset mid-fill:
  - The in-flight fill is discarded and all tv are cleared immediately (asynchronous).
  - No fill occurs after deassertion.
- busy = inflight.

## Test plan
- Reset; write 0x0000_0000_0000_1234 to addr 5; raise req[0] with addr 5 at cycle t -> valid[0]=0 in t and t+1, valid[0]=1 with rdata=0x1234 in t+2.
- Preload addrs 1..4 with 0x11..0x44; raise req[3:0] together with addrs 1,2,3,4 at t -> valid rises for ports 0,1,2,3 at t+2,t+3,t+4,t+5 with the matching data; rr=0 afterwards.
- BYPASS=1, port 1 hit on addr 7: write 0xDEAD to addr 7 -> valid[1] stays 1, rdata[1]=0xDEAD next cycle. Repeat with BYPASS=0 -> valid[1]=0 next cycle, then 0xDEAD after refill.
- Port 2 misses on addr 9 (old value 0x1) with we/wa=9/wd=0xBEEF in the grant cycle -> filled rdata[2]=0xBEEF. Repeat with the write in the fill cycle -> 0xBEEF.
- Port 0 changes addr every cycle (constant miss) while port 3 requests addr 0x20 -> port 3 granted within NPORTS cycles of first miss.
- Assert reset in the fill cycle of a port-1 read -> valid[1]=0 immediately, busy=0; after deassertion the port re-misses and fills in 2 cycles.
